// File: rtl/conv_enc_pkg.sv
// Shared types and defaults for the convolutional encoder family.
package conv_enc_pkg;

  // Encoder control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } enc_state_t;

  // Default code: LTE rate-1/3, constraint length 7
  localparam int K_DEF     = 7;
  localparam int N_OUT_DEF = 3;

  // Stream 0 uses the leftmost (most significant) generator, stream 1 the next, ...
  localparam logic [N_OUT_DEF*K_DEF-1:0] LTE_GEN = {7'o133, 7'o171, 7'o165};

endpackage

// File: rtl/conv_shift_core.sv
// Encoder shift register and per-stream parity.
// The register holds the K-1 previous bits; sreg[K-2] is the most recent.
// Parity taps: tap bit K-1 multiplies the current input, tap bit K-2 the
// most recent past bit, down to tap bit 0 on the oldest.
module conv_shift_core #(
  parameter int K = 7,
  parameter int N_OUT = 3,
  parameter logic [N_OUT*K-1:0] GEN = {7'o133, 7'o171, 7'o165}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [K-2:0]     load_val,
  input  logic             shift,
  input  logic             din,
  output logic [K-2:0]     sreg,
  output logic [N_OUT-1:0] parity
);

  // XOR of the tapped window bits
  function automatic logic tap_parity(input logic [K-1:0] taps, input logic [K-1:0] win);
    return ^(taps & win);
  endfunction

  // Load at block start, otherwise shift the new bit in at the top
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= load_val;
    end else if (shift) begin
      sreg <= (K-1)'({din, sreg} >> 1);
    end
  end

  // One parity bit per generator over the window {current, history}
  always_comb begin
    parity = '0;
    for (int i = 0; i < N_OUT; i++) begin
      parity[i] = tap_parity(GEN[(N_OUT-1-i)*K +: K], {din, sreg});
    end
  end

endmodule

// File: rtl/conv_encoder_gen2.sv
// Block convolutional encoder: pulls bits LSB-first from a show-ahead FIFO,
// emits one N_OUT-bit coded symbol per information bit through a
// valid/ready register, in tail-biting or zero-terminated mode.
module conv_encoder_gen2
  import conv_enc_pkg::*;
#(
  parameter int K = K_DEF,
  parameter int N_OUT = N_OUT_DEF,
  parameter int DATA_W = 8,
  parameter int LEN_W = 13,
  parameter logic [N_OUT*K-1:0] GEN = LTE_GEN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [LEN_W-1:0]  blk_len,
  input  logic [K-2:0]      tail_bits,
  input  logic [DATA_W-1:0] blk_data,
  input  logic              blk_empty,
  output logic              blk_rdreq,
  output logic [N_OUT-1:0]  d_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              err
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int FC_W  = (K > 2) ? $clog2(K-1) : 1;

  enc_state_t        state, state_nxt;
  logic [LEN_W-1:0]  cnt;
  logic [LEN_W-1:0]  len_q;
  logic              mode_q;
  logic [IDX_W-1:0]  bit_idx;
  logic [FC_W-1:0]   fcnt;

  logic              len_ok;
  logic              load;
  logic              out_free;
  logic              adv;
  logic              fadv;
  logic              last_bit;
  logic              last_flush;
  logic              din;
  logic [K-2:0]      load_val;
  logic [N_OUT-1:0]  parity;

  // Block lengths must be a non-zero whole number of FIFO words
  assign len_ok     = (blk_len != '0) && ((blk_len % LEN_W'(DATA_W)) == '0);
  assign load       = (state == IDLE) && start && len_ok;
  assign load_val   = mode ? '0 : tail_bits;
  assign out_free   = !out_valid || out_ready;
  assign adv        = (state == RUN) && !blk_empty && out_free;
  assign fadv       = (state == FLUSH) && out_free;
  assign last_bit   = (cnt == len_q - LEN_W'(1));
  assign last_flush = (fcnt == FC_W'(K-2));
  // Flush feeds zeros; bit_idx tracks cnt % DATA_W since blocks start word-aligned
  assign din        = (state == RUN) ? blk_data[bit_idx] : 1'b0;
  assign blk_rdreq  = adv && (bit_idx == IDX_W'(DATA_W-1));
  assign busy       = (state != IDLE);

  conv_shift_core #(
    .K     (K),
    .N_OUT (N_OUT),
    .GEN   (GEN)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .shift    (adv || fadv),
    .din      (din),
    .sreg     (),
    .parity   (parity)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = RUN;
      RUN:     if (adv && last_bit) state_nxt = mode_q ? FLUSH : DONE;
      FLUSH:   if (fadv && last_flush) state_nxt = DONE;
      DONE:    if (out_free) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Block bookkeeping: latched parameters, bit counter, word index, flush count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      len_q   <= '0;
      mode_q  <= 1'b0;
      bit_idx <= '0;
      fcnt    <= '0;
    end else if (load) begin
      cnt     <= '0;
      len_q   <= blk_len;
      mode_q  <= mode;
      bit_idx <= '0;
      fcnt    <= '0;
    end else if (adv) begin
      cnt     <= cnt + LEN_W'(1);
      bit_idx <= (bit_idx == IDX_W'(DATA_W-1)) ? '0 : bit_idx + IDX_W'(1);
    end else if (fadv) begin
      fcnt    <= fcnt + FC_W'(1);
    end
  end

  // Output symbol register: load on advance, drop valid once accepted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      d_out     <= '0;
    end else if (adv || fadv) begin
      out_valid <= 1'b1;
      d_out     <= parity;
      out_last  <= adv ? (last_bit && !mode_q) : last_flush;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

  // Rejected start pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err <= 1'b0;
    end else begin
      err <= (state == IDLE) && start && !len_ok;
    end
  end

endmodule

// File: tb/tb_conv_encoder_gen2.sv
// Bench for conv_encoder_gen2: FIFO model, random handshake, and a
// convolution reference computed directly from the block bit sequence.
module tb_conv_encoder_gen2;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        mode;
  logic [12:0] blk_len;
  logic [5:0]  tail_bits;
  logic [7:0]  blk_data;
  logic        blk_empty;
  logic        blk_rdreq;
  logic [2:0]  d_out;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        err;

  int passed = 0;
  int total  = 0;

  logic [7:0]  mem [0:2047];
  logic [10:0] rd_ptr = '0;
  logic [10:0] wr_cnt = '0;
  logic        gate_empty = 1'b0;
  bit          rnd_rdy = 0;
  bit          rnd_empty = 0;

  int          pops, pop_empty, stab_err, err_seen;
  logic        prev_stall;
  logic [3:0]  prev_out;
  logic [3:0]  syms [$];

  assign blk_empty = gate_empty || (rd_ptr >= wr_cnt);
  assign blk_data  = mem[rd_ptr];

  always #5 clk = ~clk;

  conv_encoder_gen2 dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mode      (mode),
    .blk_len   (blk_len),
    .tail_bits (tail_bits),
    .blk_data  (blk_data),
    .blk_empty (blk_empty),
    .blk_rdreq (blk_rdreq),
    .d_out     (d_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .err       (err)
  );

  // Block bit p; negative positions wrap (tail-biting) or read zero; past the end is flush zero
  function automatic logic xbit(input int p, input int len, input logic md);
    logic [7:0] w;
    int q;
    q = p;
    if (q >= len) return 1'b0;
    if (q < 0) begin
      if (md) return 1'b0;
      q = q + len;
    end
    w = mem[11'(q >> 3)];
    return w[q[2:0]];
  endfunction

  // Symbol n: d_i = XOR_j g_i[6-j] * x[n-j]
  function automatic logic [2:0] model_d(input int n, input int len, input logic md);
    logic [6:0] g;
    logic [2:0] d;
    logic acc;
    for (int i = 0; i < 3; i++) begin
      g = (i == 0) ? 7'o133 : (i == 1) ? 7'o171 : 7'o165;
      acc = 1'b0;
      for (int j = 0; j < 7; j++) acc = acc ^ (g[6-j] & xbit(n - j, len, md));
      d[i] = acc;
    end
    return d;
  endfunction

  // One clock: observe before the edge, apply FIFO pop and new random inputs after it
  task automatic tick();
    logic pop;
    @(negedge clk);
    if (prev_stall && !(out_valid && ({out_last, d_out} == prev_out))) stab_err++;
    prev_stall = out_valid && !out_ready;
    prev_out   = {out_last, d_out};
    if (out_valid && out_ready) syms.push_back({out_last, d_out});
    pop = blk_rdreq;
    if (blk_rdreq && blk_empty) pop_empty++;
    if (err) err_seen++;
    @(posedge clk);
    #1;
    if (pop) begin
      rd_ptr = rd_ptr + 11'd1;
      pops++;
    end
    out_ready  = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    gate_empty = rnd_empty ? ($urandom_range(0, 2) == 0) : 1'b0;
  endtask

  // Encode one block and check it against the reference; inj >= 0 injects starts mid-block
  task automatic run_block(input logic md, input int len, input bit fresh, input bit rr,
                           input bit re, input int inj, input string nm);
    int nsym, budget, cyc, bad, first_bad;
    logic [5:0] tail;
    logic [3:0] exp_s;
    logic [5:0] exp_state;
    if (fresh) for (int w = 0; w < len / 8; w++) mem[w] = 8'($urandom);
    for (int j = 0; j < 6; j++) tail[j] = xbit(len - 6 + j, len, 1'b0);
    rd_ptr = '0; wr_cnt = 11'(len / 8);
    pops = 0; pop_empty = 0; stab_err = 0; err_seen = 0; prev_stall = 1'b0;
    syms.delete();
    rnd_rdy = rr; rnd_empty = re;
    start = 1'b1; mode = md; blk_len = 13'(len); tail_bits = tail;
    tick();
    start = 1'b0;
    nsym = len + (md ? 6 : 0);
    budget = 30 * len + 200;
    cyc = 0;
    while ((syms.size() < nsym || busy) && cyc < budget) begin
      if (inj >= 0 && cyc == inj) begin
        start = 1'b1; blk_len = 13'd16; mode = ~md;
      end else if (inj >= 0 && cyc == inj + 3) begin
        start = 1'b1; blk_len = 13'd12;
      end else begin
        start = 1'b0;
      end
      tick();
      cyc++;
    end
    start = 1'b0; rnd_rdy = 0; rnd_empty = 0; out_ready = 1'b1; gate_empty = 1'b0;

    total++;
    if (cyc >= budget) $display("FAIL %s timeout: busy=%0d syms=%0d need %0d", nm, busy, syms.size(), nsym);
    else passed++;

    total++;
    if (syms.size() !== nsym) $display("FAIL %s count: got %0d need %0d", nm, syms.size(), nsym);
    else passed++;

    bad = 0; first_bad = -1;
    for (int n = 0; n < syms.size() && n < nsym; n++) begin
      exp_s = {(n == nsym - 1), model_d(n, len, md)};
      if (syms[n] !== exp_s) begin
        if (first_bad < 0) first_bad = n;
        bad++;
      end
    end
    total++;
    if (bad != 0)
      $display("FAIL %s symbols: %0d wrong, first at %0d got %h need %h", nm, bad, first_bad,
               syms[first_bad], {(first_bad == nsym - 1), model_d(first_bad, len, md)});
    else passed++;

    total++;
    if (pops !== len / 8) $display("FAIL %s pops: got %0d need %0d", nm, pops, len / 8);
    else passed++;

    total++;
    if (pop_empty !== 0) $display("FAIL %s pop_while_empty: got %0d need 0", nm, pop_empty);
    else passed++;

    total++;
    if (stab_err !== 0) $display("FAIL %s stall_stability: got %0d changes need 0", nm, stab_err);
    else passed++;

    total++;
    if (err_seen !== 0) $display("FAIL %s err_during_block: got %0d need 0", nm, err_seen);
    else passed++;

    exp_state = md ? 6'd0 : tail;
    total++;
    if (dut.u_core.sreg !== exp_state)
      $display("FAIL %s final_state: got %h need %h", nm, dut.u_core.sreg, exp_state);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; mode = 1'b0; blk_len = '0; tail_bits = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({out_valid, out_last, d_out, busy, err, blk_rdreq} !== 8'd0)
      $display("FAIL reset_outputs: got %b need 00000000", {out_valid, out_last, d_out, busy, err, blk_rdreq});
    else passed++;
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reject();
    logic [12:0] lens [3];
    lens[0] = 13'd12; lens[1] = 13'd0; lens[2] = 13'd20;
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; mode = 1'b0; blk_len = lens[i];
      tick();
      start = 1'b0;
      total++;
      if (err !== 1'b1 || busy !== 1'b0)
        $display("FAIL reject_len%0d: err=%b busy=%b need err=1 busy=0", lens[i], err, busy);
      else passed++;
      tick();
      total++;
      if (err !== 1'b0 || busy !== 1'b0)
        $display("FAIL reject_len%0d_after: err=%b busy=%b need err=0 busy=0", lens[i], err, busy);
      else passed++;
    end
  endtask

  task automatic test_tail_biting();
    run_block(1'b0, 40, 1, 0, 0, -1, "tb40");
  endtask

  task automatic test_zero_term();
    run_block(1'b1, 1056, 1, 0, 0, -1, "zt1056");
  endtask

  task automatic test_random_stall();
    logic [3:0] ref_syms [$];
    int diff;
    run_block(1'b0, 40, 1, 0, 0, -1, "ref40");
    ref_syms = syms;
    run_block(1'b0, 40, 0, 1, 1, -1, "stall40");
    diff = 0;
    if (syms.size() != ref_syms.size()) diff = 1;
    else for (int n = 0; n < syms.size(); n++) if (syms[n] !== ref_syms[n]) diff++;
    total++;
    if (diff != 0) $display("FAIL stall_vs_ready: %0d differences need 0", diff);
    else passed++;
    run_block(1'b1, 64, 1, 1, 1, -1, "stall_zt64");
  endtask

  task automatic test_start_in_run();
    run_block(1'b0, 40, 1, 0, 0, 5, "start_in_run");
  endtask

  task automatic test_reset_mid();
    int cyc, p0;
    for (int w = 0; w < 768; w++) mem[w] = 8'($urandom);
    rd_ptr = '0; wr_cnt = 11'd768; pops = 0; prev_stall = 1'b0;
    syms.delete();
    rnd_rdy = 0; rnd_empty = 0;
    start = 1'b1; mode = 1'b0; blk_len = 13'd6144; tail_bits = '0;
    tick();
    start = 1'b0;
    cyc = 0;
    while (dut.cnt != 13'd500 && cyc < 2000) begin
      tick();
      cyc++;
    end
    total++;
    if (cyc >= 2000) $display("FAIL midreset_reach500: cnt=%0d need 500", dut.cnt);
    else passed++;
    #2 reset = 1'b0;
    #1;
    total++;
    if ({out_valid, out_last, d_out, busy, err, blk_rdreq} !== 8'd0)
      $display("FAIL midreset_outputs: got %b need 00000000", {out_valid, out_last, d_out, busy, err, blk_rdreq});
    else passed++;
    p0 = pops;
    repeat (3) tick();
    total++;
    if (pops !== p0 || dut.cnt !== 13'd0)
      $display("FAIL midreset_hold: pops %0d->%0d cnt=%0d need no pops cnt=0", p0, pops, dut.cnt);
    else passed++;
    reset = 1'b1;
    prev_stall = 1'b0;
    tick();
    run_block(1'b0, 40, 1, 0, 0, -1, "post_reset40");
  endtask

  initial begin
    test_reset();
    test_reject();
    test_tail_biting();
    test_zero_term();
    test_random_stall();
    test_start_in_run();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/conv_encoder_gen2.md
CONV_ENCODER_GEN2 -- requirements
Module: conv_encoder_gen2

Interface
REQ-001 SHALL have parameter K, default 7, constraint length.
REQ-002 SHALL have parameter N_OUT, default 3, number of coded output streams.
REQ-003 SHALL have parameter DATA_W, default 8, input word width.
REQ-004 SHALL have parameter LEN_W, default 13, block-length field width.
REQ-005 SHALL have parameter GEN, default {7'o133, 7'o171, 7'o165}, N_OUT×K generator taps; stream i uses GEN[i]; tap MSB = current bit.
REQ-006 SHALL have port: clk  in  1  single clock; all logic on the rising edge.
REQ-007 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-008 SHALL have port: start  in  1  one-cycle block-start pulse.
REQ-009 SHALL have port: mode  in  1  0 = tail-biting, 1 = zero-terminated; sampled at start.
REQ-010 SHALL have port: blk_len  in  LEN_W  information bits in the block; sampled at start.
REQ-011 SHALL have port: tail_bits  in  K-1  last K-1 block bits; bit K-2 is the final block bit; sampled at start.
REQ-012 SHALL have port: blk_data  in  DATA_W  show-ahead FIFO head word; LSB is sent first.
REQ-013 SHALL have port: blk_empty  in  1  FIFO empty flag.
REQ-014 SHALL have port: blk_rdreq  out  1  FIFO pop; at most one pop per cycle.
REQ-015 SHALL have port: d_out  out  N_OUT  coded bits; bit i is stream i.
REQ-016 SHALL have port: out_valid  out  1  d_out is valid.
REQ-017 SHALL have port: out_ready  in  1  downstream accepts d_out.
REQ-018 SHALL have port: out_last  out  1  marks the final coded symbol of the block.
REQ-019 SHALL have port: busy  out  1  high in every state except IDLE.
REQ-020 SHALL have port: err  out  1  one-cycle pulse when start is rejected.

Function
REQ-021 SHALL use FSM states IDLE, RUN, FLUSH, DONE.
REQ-022 IDLE: accept start only if blk_len != 0 and blk_len % DATA_W == 0.
- On accept: latch mode and blk_len, clear bit counter, go to RUN.
- Shift-state load: tail_bits if mode=0, zeros if mode=1.
- Otherwise: pulse err for one cycle and stay in IDLE.
REQ-023 start SHALL be ignored outside IDLE, with no err pulse.
REQ-024 One information bit SHALL advance only when all of these hold: state RUN, !blk_empty, and the output register is free (out_valid=0 or out_ready=1).
REQ-025 Advance SHALL: take bit u = blk_data[cnt % DATA_W]; register d_i = XOR(GEN[i] & {u, s}); shift u into s; cnt+1; set out_valid.
REQ-026 blk_rdreq SHALL be asserted in the same cycle as the advance that consumes bit DATA_W-1 of a word.
REQ-027 Underflow: if blk_empty is high at any bit position, SHALL stall (no advance, no pop) and hold all state.
REQ-028 Leaving RUN after bit blk_len-1:
- mode=0: go to DONE; that symbol carries out_last.
- mode=1: go to FLUSH.
REQ-029 FLUSH SHALL encode K-1 zero bits under the same output handshake, without FIFO pops; the last flush symbol carries out_last; then go to DONE.
REQ-030 out_valid/d_out/out_last SHALL hold stable while out_valid=1 and out_ready=0.
- Latency: 1 cycle from advance to out_valid.
- Throughput: 1 symbol per cycle under continuous ready.
REQ-031 DONE SHALL wait until the last symbol is accepted, then go to IDLE the following cycle.
REQ-032 cnt SHALL be LEN_W bits wide and SHALL never wrap; maximum block = 2^LEN_W - DATA_W bits.

Reset
REQ-033 reset=0 SHALL asynchronously force: state IDLE, cnt 0, shift state 0, blk_rdreq 0, out_valid 0, out_last 0, d_out 0, busy 0, err 0.
REQ-034 Reset mid-block SHALL abandon the block without further pops; the FIFO is not drained.

Structure
REQ-035 Shared package conv_enc_pkg SHALL hold the FSM state enum, the LTE default GEN constant, and the K/N_OUT defaults.
REQ-036 The shift register and parity XOR SHALL sit in sub-module conv_shift_core (load, shift, parity out); the FSM, counter and handshake SHALL live in the top.

Verification
REQ-037 Tail-biting, blk_len=40 with LTE GEN, random data, ready=1: 40 symbols match the golden model; final shift state equals tail_bits; 5 pops; out_last on symbol 40.
REQ-038 Zero-terminated, blk_len=1056: 1062 symbols; last 6 are flush symbols; final state 0; 132 pops.
REQ-039 Random out_ready (50%) with blk_empty toggling mid-word: output stream is bit-identical to the ready=1 run; no pop while empty; d_out stable while stalled.
REQ-040 Rejected starts: start with blk_len=12 gives err for 1 cycle and busy stays 0; start during RUN is ignored with no err.
REQ-041 Reset at cnt=500 during blk_len=6144: all outputs clear immediately; a new block of 40 bits encodes correctly.
